// File: rtl/lv_fv_pkg.sv
// Shared types for the lv_fv_gen video timing sequencer.
// State encoding, pixel bundle and counter sizing helpers.
package lv_fv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FV_SETUP,
        LINE_ACT,
        LINE_BLANK,
        FV_HOLD,
        V_BLANK
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters hold 0..n-1; never let a length of 1 collapse to 0 bits.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lv_fv_gen_if.sv
// Upstream valid/ready pixel stream feeding lv_fv_gen.
// The pixel source is the master; the sequencer is the slave.
interface lv_fv_gen_if;

    logic       pix_valid;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;
    logic       pix_ready;

    modport master (
        output pix_valid,
        output pix_r,
        output pix_g,
        output pix_b,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_r,
        input  pix_g,
        input  pix_b,
        output pix_ready
    );

endinterface

// File: rtl/lv_fv_gen.sv
// Video timing sequencer: turns a valid/ready pixel stream into
// registered FV/LV/DV framing with R/G/B, sof, underrun and frame count.
module lv_fv_gen
    import lv_fv_pkg::*;
#(
    parameter int H_ACT    = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACT    = 480,
    parameter int V_BLANK  = 45,
    parameter int FV_SETUP = 2,
    parameter int FV_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    lv_fv_gen_if.slave  pix,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        FV,
    output logic        LV,
    output logic        DV,
    output logic        sof,
    output logic        underrun,
    input  logic        underrun_clr,
    output logic [15:0] frame_cnt
);

    localparam int H_MAX = max2(max2(max2(H_ACT, H_BLANK),
                                     max2(V_BLANK, FV_SETUP)),
                                FV_HOLD);
    localparam int HW = cnt_w(H_MAX);
    localparam int VW = cnt_w(V_ACT);

    localparam logic [VW-1:0] V_LAST = VW'(V_ACT - 1);

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [HW-1:0] len;
    logic          last;
    logic          ready;
    logic          accept;

    logic          fv_q, fv_d;
    logic          lv_q, lv_d;
    logic          dv_q, dv_d;
    logic          sof_q, sof_d;
    logic          underrun_q, underrun_d;
    rgb_t          rgb_q, rgb_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    // Terminal count of the shared cycle counter for the current state.
    always_comb begin
        len = '0;
        unique case (state_q)
            lv_fv_pkg::FV_SETUP: len = HW'(FV_SETUP - 1);
            LINE_ACT:            len = HW'(H_ACT - 1);
            LINE_BLANK:          len = HW'(H_BLANK - 1);
            lv_fv_pkg::FV_HOLD:  len = HW'(FV_HOLD - 1);
            lv_fv_pkg::V_BLANK:  len = HW'(V_BLANK - 1);
            default:             len = '0;
        endcase
    end

    assign last = (h_cnt_q == len);

    always_comb begin
        state_d = state_q;
        v_cnt_d = v_cnt_q;
        h_cnt_d = h_cnt_q + HW'(1);
        unique case (state_q)
            IDLE: begin
                v_cnt_d = '0;
                if (en) state_d = lv_fv_pkg::FV_SETUP;
            end
            lv_fv_pkg::FV_SETUP: begin
                v_cnt_d = '0;
                if (last) state_d = LINE_ACT;
            end
            LINE_ACT: begin
                if (last) begin
                    if (v_cnt_q == V_LAST) state_d = lv_fv_pkg::FV_HOLD;
                    else                   state_d = LINE_BLANK;
                end
            end
            LINE_BLANK: begin
                if (last) begin
                    state_d = LINE_ACT;
                    v_cnt_d = v_cnt_q + VW'(1);
                end
            end
            lv_fv_pkg::FV_HOLD: begin
                if (last) state_d = lv_fv_pkg::V_BLANK;
            end
            lv_fv_pkg::V_BLANK: begin
                if (last) begin
                    if (en) state_d = lv_fv_pkg::FV_SETUP;
                    else    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) h_cnt_d = '0;
    end

    assign ready         = (state_q == LINE_ACT);
    assign accept        = ready && pix.pix_valid;
    assign pix.pix_ready = ready;

    always_comb begin
        fv_d = state_q inside {lv_fv_pkg::FV_SETUP, LINE_ACT,
                               LINE_BLANK, lv_fv_pkg::FV_HOLD};
        lv_d  = ready;
        dv_d  = accept;
        sof_d = (state_q == lv_fv_pkg::FV_SETUP) && (h_cnt_q == '0);
        rgb_d = '0;
        if (accept) rgb_d = '{r: pix.pix_r, g: pix.pix_g, b: pix.pix_b};
        // A missing pixel beats a simultaneous clear.
        underrun_d = underrun_q;
        if (ready && !pix.pix_valid) underrun_d = 1'b1;
        else if (underrun_clr)       underrun_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if ((state_q == lv_fv_pkg::FV_HOLD) && last)
            frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            dv_q        <= 1'b0;
            sof_q       <= 1'b0;
            underrun_q  <= 1'b0;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            dv_q        <= dv_d;
            sof_q       <= sof_d;
            underrun_q  <= underrun_d;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign R         = rgb_q.r;
    assign G         = rgb_q.g;
    assign B         = rgb_q.b;
    assign FV        = fv_q;
    assign LV        = lv_q;
    assign DV        = dv_q;
    assign sof       = sof_q;
    assign underrun  = underrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lv_fv_gen.sv
// Self-checking bench for lv_fv_gen with a 20-cycle frame:
// per-cycle framing table plus a pixel scoreboard queue.
module tb_lv_fv_gen;
    import lv_fv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [7:0]  R, G, B;
    logic        FV, LV, DV, sof, underrun;
    logic [15:0] frame_cnt;

    lv_fv_gen_if pif ();

    lv_fv_gen #(
        .H_ACT(4), .H_BLANK(2), .V_ACT(3),
        .V_BLANK(2), .FV_SETUP(1), .FV_HOLD(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pix(pif),
        .R(R),
        .G(G),
        .B(B),
        .FV(FV),
        .LV(LV),
        .DV(DV),
        .sof(sof),
        .underrun(underrun),
        .underrun_clr(underrun_clr),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic valid;
        logic fv;
        logic lv;
        logic sof;
    } vec_t;

    vec_t       vec[20];
    rgb_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] seq = 8'd0;
    logic       ur_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_FV"}, FV, 0);
        chk({tag, "_LV"}, LV, 0);
        chk({tag, "_DV"}, DV, 0);
        chk({tag, "_sof"}, sof, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_RGB"}, {R, G, B}, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_pix_ready"}, pif.pix_ready, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        underrun_clr = 1'b0;
        pif.pix_valid = 1'b1;
        pif.pix_r = 8'd0;
        pif.pix_g = 8'd0;
        pif.pix_b = 8'd0;
        exp_q.delete();
        ur_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // en seen at the next edge moves to FV_SETUP; FV follows an edge later.
    task automatic start();
        en = 1'b1;
        @(negedge clk);
        chk("FV_setup_lag", FV, 0);
    endtask

    task automatic run_cycles(input int ncyc, input int drop_c,
                              input int clr_c, input int endrop_c);
        for (int c = 0; c < ncyc; c++) begin
            int   k;
            logic dv_e;
            rgb_t px;
            rgb_t got;
            k  = c % 20;
            px = '{r: seq, g: seq + 8'd1, b: ~seq};
            pif.pix_valid = vec[k].valid && (c != drop_c);
            pif.pix_r = px.r;
            pif.pix_g = px.g;
            pif.pix_b = px.b;
            underrun_clr = (c == clr_c);
            if (c == endrop_c) en = 1'b0;
            dv_e = vec[k].lv && pif.pix_valid;
            if (dv_e) begin
                exp_q.push_back(px);
                seq = seq + 8'd1;
            end
            if (vec[k].lv && !pif.pix_valid) ur_exp = 1'b1;
            else if (underrun_clr)          ur_exp = 1'b0;
            @(negedge clk);
            chk("FV", FV, vec[k].fv);
            chk("LV", LV, vec[k].lv);
            chk("DV", DV, dv_e);
            chk("sof", sof, vec[k].sof);
            chk("underrun", underrun, ur_exp);
            got = {R, G, B};
            if (dv_e) begin
                chk("pix_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("RGB", got, exp_q.pop_front());
            end else begin
                chk("RGB_idle", got, 0);
            end
        end
        underrun_clr = 1'b0;
        pif.pix_valid = 1'b1;
    endtask

    initial begin
        logic [19:0] fv_pat;
        logic [19:0] lv_pat;
        fv_pat = 20'b11111111111111111100;
        lv_pat = 20'b01111001111001111000;
        for (int k = 0; k < 20; k++) begin
            vec[k].valid = 1'b1;
            vec[k].fv    = fv_pat[19-k];
            vec[k].lv    = lv_pat[19-k];
            vec[k].sof   = (k == 0);
        end
        pif.pix_valid = 1'b0;
        pif.pix_r = 8'd0;
        pif.pix_g = 8'd0;
        pif.pix_b = 8'd0;

        #2 chk_zero("in_rst");
        do_reset();
        chk_zero("idle");

        // Basic frame
        start();
        run_cycles(20, -1, -1, -1);
        chk("basic_frame_cnt", frame_cnt, 1);
        chk("basic_q_drained", exp_q.size(), 0);

        // en dropped during line 2
        do_reset();
        start();
        run_cycles(20, -1, -1, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("endrop_FV", FV, 0);
            chk("endrop_LV", LV, 0);
            chk("endrop_ready", pif.pix_ready, 0);
        end
        chk("endrop_frame_cnt", frame_cnt, 1);

        // Back-to-back frames
        do_reset();
        start();
        run_cycles(60, -1, -1, -1);
        chk("b2b_frame_cnt", frame_cnt, 3);

        // Underrun: set, set-beats-clear, then clear
        do_reset();
        start();
        run_cycles(20, 2, -1, -1);
        chk("ur_after_f1", underrun, 1);
        run_cycles(20, 8, 8, -1);
        chk("ur_set_wins", underrun, 1);
        run_cycles(20, -1, 5, -1);
        chk("ur_cleared", underrun, 0);
        chk("ur_frame_cnt", frame_cnt, 3);

        // Async reset while in LINE_ACT
        do_reset();
        start();
        run_cycles(3, -1, -1, -1);
        chk("pre_rst_LV", LV, 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        en = 1'b0;
        exp_q.delete();
        ur_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_FV", FV, 0);
        start();
        run_cycles(20, -1, -1, -1);
        chk("post_rst_frame_cnt", frame_cnt, 1);

        // frame_cnt wrap
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        start();
        run_cycles(20, -1, -1, -1);
        chk("wrap_frame_cnt", frame_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lv_fv_gen.md
Name: lv_fv_gen

Overview:
- Video timing sequencer that drives the lv_fv_data signal set (R, G, B, FV, LV, DV) from a valid/ready pixel stream.
- Generates frame (FV), line (LV) and data-valid (DV) framing with programmable active, blank, setup and hold periods.
- Pulls pixels from an upstream source only during active line time and flags underruns.
- Sits between a pixel producer (pattern generator or frame buffer reader) and any lv_fv_data consumer: sink model, serializer or display bridge.

Parameters:
- H_ACT, 640, active pixel cycles per line (>=1)
- H_BLANK, 160, LV-low cycles between lines inside a frame (>=1)
- V_ACT, 480, active lines per frame (>=1)
- V_BLANK, 45, FV-low cycles between frames (>=1)
- FV_SETUP, 2, cycles with FV high before the first LV of a frame (>=1)
- FV_HOLD, 2, cycles with FV high after the last LV of a frame (>=1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable, sampled only at frame boundaries
- pix_valid  in  1  upstream pixel available
- pix_r / pix_g / pix_b  in  8 each  upstream pixel colour
- pix_ready  out  1  pixel accepted this cycle when pix_valid is also high
- R / G / B  out  8 each  output pixel
- FV  out  1  frame valid
- LV  out  1  line valid
- DV  out  1  data valid
- sof  out  1  one-cycle pulse, first FV-high cycle of a frame
- underrun  out  1  sticky flag: pixel missing during active time
- underrun_clr  in  1  clears underrun
- frame_cnt  out  16  completed-frame count, wraps at 0xFFFF -> 0

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- FSM states and transitions:
  - IDLE -> FV_SETUP when en=1.
  - FV_SETUP: FV_SETUP cycles, then LINE_ACT.
  - LINE_ACT: H_ACT cycles. Then LINE_BLANK if v_cnt < V_ACT-1, else FV_HOLD.
  - LINE_BLANK: H_BLANK cycles, then LINE_ACT with v_cnt+1.
  - FV_HOLD: FV_HOLD cycles, then V_BLANK.
  - V_BLANK: V_BLANK cycles. Then FV_SETUP if en=1, else IDLE.
- en deasserted mid-frame: the current frame completes in full; en is only sampled in IDLE and on the last V_BLANK cycle.
- Cycle counter h_cnt is reused by every timed state and reloads to 0 on each state change. Widths are $clog2 of the largest timed parameter and of V_ACT.
- Combinational outputs from state: pix_ready = (state==LINE_ACT). The upstream must not see ready outside active time.
- Registered outputs, all with 1-cycle latency from state/handshake:
  - FV = 1 in FV_SETUP, LINE_ACT, LINE_BLANK and FV_HOLD.
  - LV = 1 in LINE_ACT.
  - DV = pix_valid && pix_ready.
  - R/G/B load pix_* on accept and are 0 otherwise; no stale data while DV=0.
- Underrun: in LINE_ACT with pix_valid=0, output DV=0 and RGB=0, set underrun, and do not stretch timing. The line keeps exactly H_ACT LV cycles.
- underrun_clr together with a new underrun in the same cycle: set wins.
- sof is registered and is high in the first FV=1 output cycle.
- frame_cnt increments on the registered transition FV_HOLD -> V_BLANK.
- Frame period = FV_SETUP + V_ACT*H_ACT + (V_ACT-1)*H_BLANK + FV_HOLD + V_BLANK cycles.
- Reset asserted mid-frame: all outputs drop to 0 immediately and asynchronously. After release the FSM restarts from IDLE; no partial-frame resume.

Decomposition:
- Package lv_fv_pkg holds:
  - typedef enum logic [2:0] state_e with IDLE, FV_SETUP, LINE_ACT, LINE_BLANK, FV_HOLD, V_BLANK;
  - typedef struct rgb_t of three 8-bit fields.
- Sub-module: none required. The single FSM plus counters fits one module; the output register stage may optionally be split into lv_fv_out_reg.

Test Plan:
- Common parameters: H_ACT=4, H_BLANK=2, V_ACT=3, V_BLANK=2, FV_SETUP=1, FV_HOLD=1, so the frame period is 20 cycles.
- Basic frame:
  - Stimulus: en=1, pix_valid=1 constant, incrementing RGB.
  - Required: FV high 18 consecutive cycles then low 2.
  - Required: LV pattern 1 low, 4 high, 2 low, 4 high, 2 low, 4 high, 1 low.
  - Required: DV equals LV, 12 pixels out in order, frame_cnt=1 after the frame.
- Underrun:
  - Stimulus: drop pix_valid for cycle 2 of line 1.
  - Required: DV=0 and RGB=0 on that cycle, LV unchanged (4 cycles), underrun=1 and held.
  - Required: underrun_clr pulse returns it to 0.
- en drop mid-frame:
  - Stimulus: deassert en during line 2.
  - Required: frame completes with all 3 lines, then the FSM stays IDLE with FV=0 and frame_cnt=1.
- Back-to-back frames:
  - Stimulus: en held high for 3 frames.
  - Required: sof pulses exactly at cycles 0, 20 and 40 relative to the first FV.
  - Required: frame_cnt=3.
- Async reset in LINE_ACT:
  - Stimulus: assert rst for one cycle.
  - Required: all outputs 0 without waiting for a clock edge.
  - Required: after release, the next FV rises exactly 2 cycles after en is seen high (IDLE->FV_SETUP, then the output register).
- frame_cnt wrap:
  - Stimulus: preload frame_cnt to 0xFFFF via hierarchical force, then run one frame.
  - Required: frame_cnt=0x0000.
